// File: rtl/ltc_dac_array_ctrl.sv
// SPI write controller for an array of LTC2612 DACs on the lclk domain.
// Queues commands in a small FIFO and emits one CS-framed write per entry, to one chip or broadcast.
module ltc_dac_array_ctrl #(
  parameter int N_DAC      = 2,
  parameter int SEL_W      = 4,
  parameter int FRAME_BITS = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int SCK_HALF   = 150,
  parameter int CS_SETUP   = 150,
  parameter int CS_HOLD    = 150,
  parameter int CS_GAP     = 150
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_bcast,
  input  logic [SEL_W-1:0]              cmd_sel,
  input  logic [FRAME_BITS-1:0]         cmd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [N_DAC-1:0]              dac_csn,
  output logic                          dac_sck,
  output logic                          dac_sdi
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int EW   = 1 + SEL_W + FRAME_BITS;
  localparam int T01  = (SCK_HALF > CS_SETUP) ? SCK_HALF : CS_SETUP;
  localparam int T23  = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int TMAX = (T01 > T23) ? T01 : T23;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  localparam logic [TW-1:0]  T_SETUP = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0]  T_HALF  = TW'(SCK_HALF - 1);
  localparam logic [TW-1:0]  T_HOLD  = TW'(CS_HOLD - 1);
  localparam logic [TW-1:0]  T_GAP   = TW'(CS_GAP - 1);
  localparam logic [SEL_W:0] N_DAC_L = (SEL_W + 1)'(N_DAC);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_t;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  push, pop;
  logic [EW-1:0]         head;
  logic                  head_bcast, head_bad;
  logic [SEL_W-1:0]      head_sel;
  logic [FRAME_BITS-1:0] head_data;
  logic [N_DAC-1:0]      head_mask;

  state_t                state, state_nxt;
  logic [TW-1:0]         timer, timer_nxt;
  logic [BW-1:0]         bit_cnt, bit_nxt;
  logic [FRAME_BITS-1:0] shreg, shreg_nxt, shreg_sh;
  logic [N_DAC-1:0]      csn_nxt;
  logic                  sck_nxt, sdi_nxt, done_nxt, err_nxt, busy_nxt;

  assign cmd_ready  = (count != CW'(FIFO_DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_bcast, cmd_sel, cmd_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head       = mem[rd_ptr];
  assign head_bcast = head[EW-1];
  assign head_sel   = head[FRAME_BITS +: SEL_W];
  assign head_data  = head[FRAME_BITS-1:0];
  // Full-width compare so select bits beyond the chip range flag an error instead of aliasing.
  assign head_bad   = !head_bcast && ({1'b0, head_sel} >= N_DAC_L);

  always_comb begin
    head_mask = '1;
    if (head_bcast) begin
      head_mask = '0;
    end else begin
      for (int i = 0; i < N_DAC; i++) begin
        if (head_sel == SEL_W'(i)) head_mask[i] = 1'b0;
      end
    end
  end

  assign shreg_sh = shreg << 1;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    csn_nxt   = dac_csn;
    sck_nxt   = dac_sck;
    sdi_nxt   = dac_sdi;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          if (head_bad) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt = SETUP;
            timer_nxt = T_SETUP;
            bit_nxt   = BW'(FRAME_BITS - 1);
            shreg_nxt = head_data;
            csn_nxt   = head_mask;
            sdi_nxt   = head_data[FRAME_BITS-1];
          end
        end
      end
      SETUP: begin
        if (timer == '0) begin
          state_nxt = SHIFT_HI;
          timer_nxt = T_HALF;
          sck_nxt   = 1'b1;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      SHIFT_HI: begin
        if (timer == '0) begin
          state_nxt = SHIFT_LO;
          timer_nxt = T_HALF;
          sck_nxt   = 1'b0;
          shreg_nxt = shreg_sh;
          sdi_nxt   = shreg_sh[FRAME_BITS-1];
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      SHIFT_LO: begin
        if (timer == '0) begin
          if (bit_cnt == '0) begin
            state_nxt = HOLD;
            timer_nxt = T_HOLD;
            sdi_nxt   = 1'b0;
          end else begin
            state_nxt = SHIFT_HI;
            timer_nxt = T_HALF;
            bit_nxt   = bit_cnt - 1'b1;
            sck_nxt   = 1'b1;
          end
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      HOLD: begin
        if (timer == '0) begin
          state_nxt = GAP;
          timer_nxt = T_GAP;
          csn_nxt   = '1;
          done_nxt  = 1'b1;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      GAP: begin
        if (timer == '0) state_nxt = IDLE;
        else             timer_nxt = timer - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      dac_csn <= '1;
      dac_sck <= 1'b0;
      dac_sdi <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      dac_csn <= csn_nxt;
      dac_sck <= sck_nxt;
      dac_sdi <= sdi_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      busy    <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_ltc_dac_array_ctrl.sv
// Bench for ltc_dac_array_ctrl: a 3-DAC instance with default timing and a fast 2-DAC/8-bit instance.
// One pin monitor follows whichever instance is selected and records frame shape and sampled bits.
module tb_ltc_dac_array_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #4 clk = ~clk;

  logic        valid_a, bcast_a, ready_a, busy_a, done_a, err_a, sck_a, sdi_a;
  logic [1:0]  sel_a;
  logic [23:0] data_a;
  logic [2:0]  count_a, csn_a;

  logic        valid_b, bcast_b, ready_b, busy_b, done_b, err_b, sck_b, sdi_b;
  logic [1:0]  sel_b, count_b, csn_b;
  logic [7:0]  data_b;

  ltc_dac_array_ctrl #(.N_DAC(3), .SEL_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(valid_a), .cmd_ready(ready_a),
    .cmd_bcast(bcast_a), .cmd_sel(sel_a), .cmd_data(data_a), .fifo_count(count_a),
    .busy(busy_a), .done(done_a), .err(err_a), .dac_csn(csn_a), .dac_sck(sck_a), .dac_sdi(sdi_a));

  ltc_dac_array_ctrl #(.N_DAC(2), .SEL_W(2), .FRAME_BITS(8), .FIFO_DEPTH(2), .SCK_HALF(1),
                       .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(valid_b), .cmd_ready(ready_b),
    .cmd_bcast(bcast_b), .cmd_sel(sel_b), .cmd_data(data_b), .fifo_count(count_b),
    .busy(busy_b), .done(done_b), .err(err_b), .dac_csn(csn_b), .dac_sck(sck_b), .dac_sdi(sdi_b));

  logic       mon_b = 1'b0;
  logic [2:0] m_csn;
  logic       m_sck, m_sdi, m_done, m_err, m_busy;
  assign m_csn  = mon_b ? {1'b1, csn_b} : csn_a;
  assign m_sck  = mon_b ? sck_b  : sck_a;
  assign m_sdi  = mon_b ? sdi_b  : sdi_a;
  assign m_done = mon_b ? done_b : done_a;
  assign m_err  = mon_b ? err_b  : err_a;
  assign m_busy = mon_b ? busy_b : busy_a;

  int          cyc = 0, rises = 0, frames = 0, fdone = 0, dones = 0, errs = 0, sck_bad = 0;
  int          fall_cyc = 0, period = 0, low_w = 0, last_rises = 0;
  logic [31:0] sh = '0, last_bits = '0;
  logic [2:0]  p_csn = '1, last_csn = '1;
  logic        p_sck = 1'b0;

  always @(negedge clk) begin
    cyc   <= cyc + 1;
    p_csn <= m_csn;
    p_sck <= m_sck;
    if (m_done) dones <= dones + 1;
    if (m_err)  errs  <= errs + 1;
    if (m_sck != p_sck && &m_csn && &p_csn) sck_bad <= sck_bad + 1;
    if (m_sck && !p_sck) begin
      rises <= rises + 1;
      sh    <= {sh[30:0], m_sdi};
    end
    if (&p_csn && !(&m_csn)) begin
      frames   <= frames + 1;
      period   <= cyc - fall_cyc;
      fall_cyc <= cyc;
      rises    <= 0;
      sh       <= '0;
      last_csn <= m_csn;
    end
    if (!(&p_csn) && &m_csn) begin
      fdone      <= fdone + 1;
      low_w      <= cyc - fall_cyc;
      last_rises <= rises;
      last_bits  <= sh;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (fdone < n && k < budget) begin @(negedge clk); k++; end
    @(negedge clk);
    chk("frame_timeout", 32'(fdone >= n), 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    @(negedge clk);
    while (m_busy && k < budget) begin @(negedge clk); k++; end
    chk("idle_timeout", 32'(m_busy), 0);
  endtask

  task automatic push_a(input logic b, input logic [1:0] s, input logic [23:0] d);
    @(posedge clk); #1;
    valid_a = 1'b1; bcast_a = b; sel_a = s; data_a = d;
    @(posedge clk); #1;
    valid_a = 1'b0;
  endtask

  task automatic push_b(input logic b, input logic [1:0] s, input logic [7:0] d);
    @(posedge clk); #1;
    valid_b = 1'b1; bcast_b = b; sel_b = s; data_b = d;
    @(posedge clk); #1;
    valid_b = 1'b0;
  endtask

  typedef struct {
    logic       bcast;
    logic [1:0] sel;
    logic [7:0] data;
    logic [1:0] exp_csn;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int k, acc, fr0, d0, e0, fd0;
    logic rdy[8];

    vecs[0] = '{1'b0, 2'd0, 8'hA5, 2'b10, 1'b0};
    vecs[1] = '{1'b0, 2'd1, 8'h3C, 2'b01, 1'b0};
    vecs[2] = '{1'b1, 2'd3, 8'hFF, 2'b00, 1'b0};
    vecs[3] = '{1'b0, 2'd2, 8'h81, 2'b11, 1'b1};
    vecs[4] = '{1'b0, 2'd3, 8'h00, 2'b11, 1'b1};
    vecs[5] = '{1'b0, 2'd0, 8'h01, 2'b10, 1'b0};

    rst_n = 1'b0;
    valid_a = 0; bcast_a = 0; sel_a = 0; data_a = 0;
    valid_b = 0; bcast_b = 0; sel_b = 0; data_b = 0;
    repeat (3) @(negedge clk);
    chk("rst_csn", 32'(csn_a), 32'h7);
    chk("rst_sck_sdi", {sck_a, sdi_a}, 0);
    chk("rst_busy_done_err", {busy_a, done_a, err_a}, 0);
    chk("rst_count", 32'(count_a), 0);
    chk("rst_ready", 32'(ready_a), 1);
    @(posedge clk); #1 rst_n = 1'b1;

    // single command, sel 0, with accept-to-CS latency
    push_a(1'b0, 2'd0, 24'h3F8A5C);
    @(negedge clk);
    chk("lat_count_t1", 32'(count_a), 1);
    chk("lat_csn_t1", 32'(csn_a), 32'h7);
    chk("lat_busy_t1", 32'(busy_a), 0);
    @(negedge clk);
    chk("lat_csn_t2", 32'(csn_a), 32'h6);
    chk("lat_busy_t2", 32'(busy_a), 1);
    chk("lat_count_t2", 32'(count_a), 0);
    wait_frames(1, 8000);
    chk("single_csn", 32'(last_csn), 32'h6);
    chk("single_low_w", 32'(low_w), 7500);
    chk("single_rises", 32'(last_rises), 24);
    chk("single_bits", last_bits, 32'h3F8A5C);
    chk("single_dones", 32'(dones), 1);

    // broadcast ignores sel
    push_a(1'b1, 2'd1, 24'h300FFF);
    wait_frames(2, 8200);
    chk("bcast_csn", 32'(last_csn), 32'h0);
    chk("bcast_low_w", 32'(low_w), 7500);
    chk("bcast_bits", last_bits, 32'h300FFF);
    chk("bcast_errs", 32'(errs), 0);

    // invalid select 3 with three chips
    wait_idle(400);
    push_a(1'b0, 2'd3, 24'h123456);
    @(negedge clk);
    chk("inv_err_t1", 32'(err_a), 0);
    @(negedge clk);
    chk("inv_err_t2", 32'(err_a), 1);
    chk("inv_csn_t2", 32'(csn_a), 32'h7);
    chk("inv_busy_t2", 32'(busy_a), 0);
    @(negedge clk);
    chk("inv_err_t3", 32'(err_a), 0);
    repeat (20) @(negedge clk);
    chk("inv_errs", 32'(errs), 1);
    chk("inv_frames", 32'(frames), 2);
    chk("inv_dones", 32'(dones), 2);
    push_a(1'b0, 2'd2, 24'hA5C3E1);
    wait_frames(3, 8000);
    chk("post_inv_csn", 32'(last_csn), 32'h3);
    chk("post_inv_bits", last_bits, 32'hA5C3E1);
    chk("post_inv_low_w", 32'(low_w), 7500);

    // back-to-back: valid held 8 cycles from idle and empty
    wait_idle(400);
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      valid_a = 1'b1; bcast_a = 1'b0; sel_a = 2'(i % 3); data_a = 24'h100000 + 24'(i);
      @(negedge clk);
      rdy[i] = ready_a;
      if (ready_a) acc++;
    end
    @(posedge clk); #1 valid_a = 1'b0;
    chk("b2b_accepted", 32'(acc), 5);
    chk("b2b_ready_c5", 32'(rdy[4]), 1);
    chk("b2b_ready_c6", 32'(rdy[5]), 0);
    wait_frames(4, 8000);
    chk("b2b_f1_bits", last_bits, 32'h100000);
    chk("b2b_f1_csn", 32'(last_csn), 32'h6);
    k = 0;
    while (frames < 5 && k < 400) begin @(negedge clk); k++; end
    @(negedge clk);
    chk("b2b_f2_start", 32'(frames), 5);
    chk("b2b_period", 32'(period), 7651);
    chk("b2b_f2_csn", 32'(last_csn), 32'h5);
    chk("b2b_queued", 32'(count_a), 3);

    // reset during bit 10 of the second burst frame
    k = 0;
    while (rises < 10 && k < 4000) begin @(negedge clk); k++; end
    chk("rst_mid_reach", 32'(rises >= 10), 1);
    fr0 = frames; d0 = dones;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_csn", 32'(csn_a), 32'h7);
    chk("rst_mid_sck", 32'(sck_a), 0);
    chk("rst_mid_count", 32'(count_a), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("rst_after_frames", 32'(frames), 32'(fr0));
    chk("rst_after_dones", 32'(dones), 32'(d0));
    chk("rst_after_csn", 32'(csn_a), 32'h7);
    chk("sck_while_cs_high", 32'(sck_bad), 0);

    // fast instance: vector table
    mon_b = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      wait_idle(50);
      e0 = errs; fd0 = fdone;
      push_b(vecs[i].bcast, vecs[i].sel, vecs[i].data);
      if (vecs[i].exp_err) begin
        repeat (6) @(negedge clk);
        chk($sformatf("vec%0d_err", i), 32'(errs - e0), 1);
        chk($sformatf("vec%0d_noframe", i), 32'(fdone - fd0), 0);
      end else begin
        wait_frames(fd0 + 1, 100);
        chk($sformatf("vec%0d_csn", i), 32'(last_csn), {29'h0, 1'b1, vecs[i].exp_csn});
        chk($sformatf("vec%0d_bits", i), last_bits, {24'h0, vecs[i].data});
        chk($sformatf("vec%0d_low_w", i), 32'(low_w), 18);
        chk($sformatf("vec%0d_rises", i), 32'(last_rises), 8);
        chk($sformatf("vec%0d_noerr", i), 32'(errs - e0), 0);
      end
    end

    // fast instance: two frames back to back
    wait_idle(50);
    fd0 = fdone;
    @(posedge clk); #1;
    valid_b = 1'b1; bcast_b = 1'b0; sel_b = 2'd1; data_b = 8'hC3;
    @(posedge clk); #1;
    data_b = 8'h5A; sel_b = 2'd0;
    @(posedge clk); #1;
    valid_b = 1'b0;
    wait_frames(fd0 + 2, 200);
    chk("fast_period", 32'(period), 20);
    chk("fast_f2_bits", last_bits, 32'h5A);
    chk("fast_f2_csn", 32'(last_csn), 32'h6);
    chk("fast_sck_while_cs_high", 32'(sck_bad), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
